matmul_seq: RTL and testbench

//  Responder side of the start_mat_mul/done_mat_mul handshake driven by the top-level control FSM.

---
 rtl/matmul_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_matmul_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// -----------------------------------------------------------------------------
// matmul_seq
//   Sequencer for one matrix-multiply pass inside the matmul unit. It answers
//   the start_mat_mul / done_mat_mul handshake from the top-level control FSM:
//   it walks the A and B BRAM read addresses for k_steps K tiles, waits for the
//   systolic array to drain, flags the window in which result rows are valid,
//   and then reports completion until the requester drops start.
//
//   start_mat_mul is a level. Dropping it in any non-idle state returns the
//   block to IDLE at the next edge, which doubles as an abort mid-run.
//
// Optional feature (compile-time macro): MATMUL_CYCLE_COUNT_EN
//   Defined   : a 32-bit run-length counter is built; o_cycles_taken reports
//               the FEED+DRAIN length of the last completed run.
//   Undefined : no counter; o_cycles_taken is tied to 0.
//
// Parameters
//   MAT_SIZE  systolic array dimension (feed cycles per K tile)
//   ADDR_W    BRAM address width
//   K_W       width of the k_steps input
//
// Ports
//   i_clk                clock
//   i_reset              synchronous, active-high reset
//   i_start_mat_mul      run request, held high until done is seen
//   i_k_steps            number of K tiles (0 behaves as 1), sampled at start
//   i_base_addr_a/b      first A/B read address, sampled at start
//   i_stride_a/b         A/B address increment per feed cycle, sampled at start
//   o_address_mat_a/b    registered A/B BRAM read address
//   o_rd_en_a/b          A/B read enable (high for every feed cycle)
//   o_c_data_available   systolic array output rows valid
//   o_busy               block is not idle
//   o_done_mat_mul       completion, held until start is dropped
//   o_cycles_taken       FEED+DRAIN cycle count of the last completed run
// -----------------------------------------------------------------------------
module matmul_seq #(
  parameter int MAT_SIZE = 4,
  parameter int ADDR_W   = 10,
  parameter int K_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start_mat_mul,
  input  logic [K_W-1:0]    i_k_steps,
  input  logic [ADDR_W-1:0] i_base_addr_a,
  input  logic [ADDR_W-1:0] i_base_addr_b,
  input  logic [ADDR_W-1:0] i_stride_a,
  input  logic [ADDR_W-1:0] i_stride_b,
  output logic [ADDR_W-1:0] o_address_mat_a,
  output logic [ADDR_W-1:0] o_address_mat_b,
  output logic              o_rd_en_a,
  output logic              o_rd_en_b,
  output logic              o_c_data_available,
  output logic              o_busy,
  output logic              o_done_mat_mul,
  output logic [31:0]       o_cycles_taken
);

  // The phase counter must hold up to (2^K_W - 1) * MAT_SIZE - 1 feed cycles
  // as well as the drain length, so size it for 2^K_W * MAT_SIZE.
  localparam int CNT_W     = $clog2((2 ** K_W) * MAT_SIZE);
  localparam int DRAIN_CYC = 2 * MAT_SIZE + 1;

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
  // Result rows appear during the final MAT_SIZE cycles of the drain.
  localparam logic [CNT_W-1:0] C_VLD_FIRST = CNT_W'(DRAIN_CYC - MAT_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_feed_last;
  logic [ADDR_W-1:0] r_stride_a;
  logic [ADDR_W-1:0] r_stride_b;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic              r_done;

  logic [K_W-1:0]    w_k_eff;
  logic [CNT_W-1:0]  w_feed_len;
  logic              w_launch;

  // A zero tile count still runs one tile.
  assign w_k_eff    = (i_k_steps == '0) ? K_W'(1) : i_k_steps;
  assign w_feed_len = CNT_W'(w_k_eff) * CNT_W'(MAT_SIZE);
  assign w_launch   = (r_state == S_IDLE) && (w_next_state == S_FEED);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state       = r_state;
    o_rd_en_a          = 1'b0;
    o_rd_en_b          = 1'b0;
    o_c_data_available = 1'b0;
    o_busy             = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (i_start_mat_mul) begin
          w_next_state = S_FEED;
        end
      end
      S_FEED: begin
        o_rd_en_a = 1'b1;
        o_rd_en_b = 1'b1;
        if (!i_start_mat_mul) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == r_feed_last) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_c_data_available = (r_cnt >= C_VLD_FIRST);
        if (!i_start_mat_mul) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == DRAIN_LAST) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_start_mat_mul) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run configuration, captured once per run; only meaningful while busy
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_launch) begin
      r_stride_a  <= i_stride_a;
      r_stride_b  <= i_stride_b;
      r_feed_last <= w_feed_len - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter, read addresses and completion flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_done   <= 1'b0;
    end else begin
      // Done is raised one edge after entering DONE and drops on the same
      // edge that sees start low.
      r_done <= (r_state == S_DONE) && (w_next_state == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt    <= '0;
            r_addr_a <= i_base_addr_a;
            r_addr_b <= i_base_addr_b;
          end
        end
        S_FEED: begin
          // Step only while another read follows, so the final feed address
          // is what remains visible through DRAIN/DONE or after an abort.
          if (w_next_state == S_FEED) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_addr_a <= r_addr_a + r_stride_a;
            r_addr_b <= r_addr_b + r_stride_b;
          end else begin
            r_cnt <= '0;
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_address_mat_a = r_addr_a;
  assign o_address_mat_b = r_addr_b;
  assign o_done_mat_mul  = r_done;

`ifdef MATMUL_CYCLE_COUNT_EN
  // ---------------------------------------------------------------------------
  // Run-length counter
  // ---------------------------------------------------------------------------
  logic [31:0] r_run_cnt;
  logic [31:0] r_cycles_taken;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run_cnt      <= '0;
      r_cycles_taken <= '0;
    end else if (w_launch) begin
      r_run_cnt      <= '0;
      r_cycles_taken <= '0;
    end else if ((r_state == S_FEED) || (r_state == S_DRAIN)) begin
      r_run_cnt <= r_run_cnt + 32'd1;
      // Capture includes the final drain cycle being counted at this edge.
      if ((r_state == S_DRAIN) && (w_next_state == S_DONE)) begin
        r_cycles_taken <= r_run_cnt + 32'd1;
      end
    end
  end

  assign o_cycles_taken = r_cycles_taken;
`else
  assign o_cycles_taken = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;

  localparam int M  = 4;
  localparam int AW = 10;
  localparam int KW = 8;
  localparam int D  = 2 * M + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_steps;
  logic [AW-1:0] base_a, base_b, stride_a, stride_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          rd_a, rd_b, c_avail, busy, done;
  logic [31:0]   cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matmul_seq #(.MAT_SIZE(M), .ADDR_W(AW), .K_W(KW)) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_start_mat_mul    (start),
    .i_k_steps          (k_steps),
    .i_base_addr_a      (base_a),
    .i_base_addr_b      (base_b),
    .i_stride_a         (stride_a),
    .i_stride_b         (stride_b),
    .o_address_mat_a    (addr_a),
    .o_address_mat_b    (addr_b),
    .o_rd_en_a          (rd_a),
    .o_rd_en_b          (rd_b),
    .o_c_data_available (c_avail),
    .o_busy             (busy),
    .o_done_mat_mul     (done),
    .o_cycles_taken     (cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is described by the number of edges m_e since
  // the start edge; every output is a plain function of that index.
  bit            m_armed = 1'b0;
  bit            m_run   = 1'b0;
  int            m_e, m_k, m_ba, m_bb, m_sa, m_sb;
  logic [AW-1:0] m_fa, m_fb;
  int            m_cyc_frz;

  function automatic int feed_len(input int k);
    return ((k == 0) ? 1 : k) * M;
  endfunction

  function automatic logic [AW-1:0] addr_at(input int base, input int stride, input int e, input int k);
    int f;
    int idx;
    logic [31:0] s;
    f   = feed_len(k);
    idx = (e < f) ? e : f - 1;
    s   = base + stride * idx;
    return s[AW-1:0];
  endfunction

  function automatic int cyc_in_run(input int e, input int k);
`ifdef MATMUL_CYCLE_COUNT_EN
    return (e >= feed_len(k) + D) ? feed_len(k) + D : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_armed   <= 1'b1;
      m_run     <= 1'b0;
      m_fa      <= '0;
      m_fb      <= '0;
      m_cyc_frz <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run     <= 1'b1;
        m_e       <= 0;
        m_k       <= int'(k_steps);
        m_ba      <= int'(base_a);
        m_bb      <= int'(base_b);
        m_sa      <= int'(stride_a);
        m_sb      <= int'(stride_b);
        m_cyc_frz <= 0;
      end
    end else if (!start) begin
      m_run     <= 1'b0;
      m_fa      <= addr_at(m_ba, m_sa, m_e, m_k);
      m_fb      <= addr_at(m_bb, m_sb, m_e, m_k);
      m_cyc_frz <= cyc_in_run(m_e, m_k);
    end else begin
      m_e <= m_e + 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_armed) begin
      int f;
      f = feed_len(m_k);
      chk("rd_en_a", rd_a,    m_run && (m_e < f));
      chk("rd_en_b", rd_b,    m_run && (m_e < f));
      chk("c_avail", c_avail, m_run && (m_e >= f + D - M) && (m_e < f + D));
      chk("done",    done,    m_run && (m_e >= f + D + 1));
      chk("busy",    busy,    m_run);
      chk("addr_a",  addr_a,  m_run ? addr_at(m_ba, m_sa, m_e, m_k) : m_fa);
      chk("addr_b",  addr_b,  m_run ? addr_at(m_bb, m_sb, m_e, m_k) : m_fb);
      chk("cycles",  cycles,  m_run ? cyc_in_run(m_e, m_k) : m_cyc_frz);
    end
  end

  logic [AW-1:0] q_addr[$];

  task automatic scramble();
    k_steps  = KW'($urandom);
    base_a   = AW'($urandom);
    base_b   = AW'($urandom);
    stride_a = AW'($urandom);
    stride_b = AW'($urandom);
  endtask

  task automatic launch(input int k, input int ba, input int bb, input int sa, input int sb);
    @(negedge clk);
    k_steps  = KW'(k);
    base_a   = AW'(ba);
    base_b   = AW'(bb);
    stride_a = AW'(sa);
    stride_b = AW'(sb);
    start    = 1'b1;
  endtask

  // Full run: returns the edge index (0 = start edge) after which done was
  // first seen, holds start `hold` more cycles, then drops it and returns
  // right after the following edge.
  task automatic run_full(input int k, input int ba, input int bb, input int sa, input int sb,
                          input int hold, output int done_edge);
    launch(k, ba, bb, sa, sb);
    done_edge = -1;
    q_addr.delete();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (n == 0) scramble();
      if (rd_a) q_addr.push_back(addr_a);
      if (done) begin
        done_edge = n;
        break;
      end
    end
    if (done_edge < 0) chk("done_timeout", {31'd0, done}, 32'd1);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Aborted run: start dropped after edge abort_n; done must never rise.
  task automatic run_abort(input int k, input int ba, input int bb, input int sa, input int sb,
                           input int abort_n);
    bit seen;
    launch(k, ba, bb, sa, sb);
    seen = 1'b0;
    for (int n = 0; n <= abort_n; n++) begin
      @(negedge clk);
      if (n == 0) scramble();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", {31'd0, rd_a}, 32'd0);
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    repeat (4 * M) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_done_never", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int de;
    int k, f, hold, ab;
    rst = 1'b1;
    start = 1'b0;
    k_steps = '0; base_a = '0; base_b = '0; stride_a = '0; stride_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy",   {31'd0, busy}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk("reset_addr_a", {22'd0, addr_a}, 32'h0);
    chk("reset_cycles", cycles, 32'd0);
    repeat (2) @(negedge clk);

    // Single tile, base 0x010, unit stride
    run_full(1, 'h010, 'h100, 1, 2, 0, de);
    chk("t1_done_edge", de, 32'd14);
    chk("t1_nreads", q_addr.size(), 32'd4);
    chk("t1_addr0", {22'd0, q_addr[0]}, 32'h010);
    chk("t1_addr3", {22'd0, q_addr[3]}, 32'h013);

    // k_steps = 0 behaves as 1; k_steps = 3
    run_full(0, 'h020, 'h040, 1, 1, 0, de);
    chk("t2_k0_done_edge", de, 32'd14);
    run_full(3, 'h000, 'h200, 4, 4, 0, de);
    chk("t2_k3_done_edge", de, 32'd22);
    chk("t2_k3_nreads", q_addr.size(), 32'd12);

    // Address wrap
    run_full(1, 'h3FE, 'h3FF, 1, 1, 0, de);
    chk("t3_w0", {22'd0, q_addr[0]}, 32'h3FE);
    chk("t3_w1", {22'd0, q_addr[1]}, 32'h3FF);
    chk("t3_w2", {22'd0, q_addr[2]}, 32'h000);
    chk("t3_w3", {22'd0, q_addr[3]}, 32'h001);

    // Hold after done, drop, rerun
    run_full(1, 'h010, 'h010, 1, 1, 5, de);
    chk("t4_done_low", {31'd0, done}, 32'd0);
    chk("t4_busy_low", {31'd0, busy}, 32'd0);
    run_full(1, 'h010, 'h010, 1, 1, 0, de);
    chk("t4_rerun_done_edge", de, 32'd14);

    // Abort in the 3rd feed cycle, then a normal run
    run_abort(1, 'h050, 'h060, 1, 1, 2);
    run_full(1, 'h050, 'h060, 1, 1, 0, de);
    chk("t5_restart_done_edge", de, 32'd14);

    // Cycle counter
    run_full(2, 'h000, 'h000, 1, 1, 0, de);
`ifdef MATMUL_CYCLE_COUNT_EN
    chk("t6_cycles", cycles, 32'd17);
`else
    chk("t6_cycles", cycles, 32'd0);
`endif

    // Reset in the middle of a run
    launch(2, 'h123, 'h321, 3, 5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
    chk("rst_mid_addr_a", {22'd0, addr_a}, 32'h0);
    chk("rst_mid_rd_en",  {31'd0, rd_a}, 32'd0);
    repeat (2) @(negedge clk);

    // Randomized runs
    for (int i = 0; i < 30; i++) begin
      k    = $urandom_range(0, 4);
      f    = ((k == 0) ? 1 : k) * M;
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
        ab = $urandom_range(0, f + D - 1);
        run_abort(k, $urandom, $urandom, $urandom, $urandom, ab);
      end else begin
        run_full(k, $urandom, $urandom, $urandom, $urandom, hold, de);
        chk("rand_done_edge", de, f + D + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
